comparador_secuencial: RTL and testbench
========================================

# comparador_secuencial

Sequential, parametrised magnitude comparator for the datapath comparison stage. It scans two WIDTH-bit operands from left to right (MSB first), DIGIT bits per clock, and reports A>B, A<=B and A==B after a start/done handshake. Signed compare and early termination on the first differing digit are supported. It keeps the w/z output semantics of the existing combinational comparator, so downstream logic is unchanged.

## Interface
- WIDTH, 8: operand width in bits; WIDTH ≥ 2.
- DIGIT, 1: bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT scan steps.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.
- EARLY_EXIT, 1: 1 = finish on the first differing digit, 0 = always scan all N digits.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a comparison; sampled only when accepting (state IDLE or DONE).
- word_a  in  WIDTH  operand A; latched when start is accepted.
- word_b  in  WIDTH  operand B; latched when start is accepted.
- busy  out  1  high while a comparison is in progress (state SCAN).
- done  out  1  one-cycle pulse; results are valid from this cycle.
- w  out  1  1 when A > B.
- z  out  1  1 when A <= B; always equal to !w.
- eq  out  1  1 when A == B.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE/DONE with start=1: latch word_a and word_b into internal registers, set digit index to N-1, clear the "difference found" flag, then go to SCAN.
- DONE with start=0: go to IDLE.
- SIGNED=1: invert bit WIDTH-1 of both operands at latch time. The scan itself is always unsigned.
- SCAN, each cycle: compare digit[index] of A and B with an unsigned DIGIT-bit compare.
  - On the first difference, record gt/lt.
  - EARLY_EXIT=1: on a difference, go to DONE.
  - Otherwise, at index 0 go to DONE; else decrement index.
  - EARLY_EXIT=0: record only the first difference; later digits are ignored.
- Entry to DONE:
  - w=gt, z=!gt, eq=!found.
  - w, z and eq hold until the next completion. They never change during SCAN.
- start while in SCAN: ignored; it is not queued.
- Changes on word_a and word_b after acceptance: ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, busy=0, done=0, w=0, z=1, eq=1, index=N-1.
- Start accepted at rising edge k: busy=1 after edge k.
- Digit j (counted from MSB, j=0..N-1) is compared in the cycle after edge k+j.
- Full scan: DONE is entered at edge k+N. done=1 and results are valid in that cycle; busy=0.
- EARLY_EXIT=1 with the first difference at step j: DONE is entered at edge k+j+1. Latency is 1..N cycles.
- Back-to-back: start=1 in the done cycle is accepted at the next edge. Throughput is one compare per N+1 cycles at worst case.
- Reset asserted mid-SCAN: the operation is aborted and all outputs take reset values. No done pulse is produced.
- done never asserts without a prior accepted start.

## Structure
- Package comparador_pkg contains:
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - a function computing N and the index width, $clog2(N) with a minimum of 1.
- Sub-module comparador_digito: combinational, DIGIT-bit unsigned compare with outputs gt and lt.
- Top level contains the FSM, operand registers, index counter and result registers.
- Elaboration check: fail if WIDTH % DIGIT != 0.

## Test plan
- WIDTH=8, DIGIT=1, EARLY_EXIT=1: A=0x00, B=0x00 -> done 8 cycles after start; w=0, z=1, eq=1.
- Same config: A=0xE7, B=0x81 -> done 2 cycles after start; w=1, z=0, eq=0. With EARLY_EXIT=0 -> done after 8 cycles, same results.
- SIGNED=1, WIDTH=8: A=0x80 (-128), B=0x01 -> w=0, z=1, eq=0. A=0x01, B=0xFF (-1) -> w=1, z=0.
- DIGIT=4, WIDTH=8: A=0x6E, B=0x6F -> done 2 cycles after start; w=0, z=1, eq=0. A=0x7E, B=0x6F -> done after 1 cycle; w=1.
- Robustness, all in one run:
  - drive start=1 and change word_a during SCAN -> both ignored; results reflect the latched operands;
  - assert reset at scan step 3 -> outputs return to w=0, z=1, eq=1, busy=0, with no done pulse;
  - assert start in the done cycle -> the new op starts with busy=1 on the next cycle.
- Randomised: 1000 random pairs per config (SIGNED 0/1, DIGIT 1/2/4/8) checked against a reference model for w, z, eq and latency.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned num_steps(input int unsigned width,
                                            input int unsigned digit);
    return width / digit;
  endfunction

  // Index counter width; a single-step scan still needs a one-bit counter.
  function automatic int unsigned idx_width(input int unsigned width,
                                            input int unsigned digit);
    int unsigned n;
    n = width / digit;
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module comparador_digito #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] dig_a,
  input  logic [DIGIT-1:0] dig_b,
  output logic             gt,
  output logic             lt
);

  assign gt = (dig_a > dig_b);
  assign lt = (dig_a < dig_b);

endmodule

// File: rtl/comparador_secuencial.sv
// MSB-first digit-serial magnitude comparator with start/done handshake.
module comparador_secuencial
  import comparador_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 1,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] word_a,
  input  logic [WIDTH-1:0] word_b,
  output logic             busy,
  output logic             done,
  output logic             w,
  output logic             z,
  output logic             eq
);

  localparam int unsigned N     = num_steps(WIDTH, DIGIT);
  localparam int unsigned IDX_W = idx_width(WIDTH, DIGIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = {SIGNED, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
      $error("comparador_secuencial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             found_q, gt_q;
  logic             w_q, eq_q;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             d_gt, d_lt, diff;
  logic             accept, last, finish;
  logic             gt_fin, found_fin;

  assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
  assign dig_b = b_q[idx_q*DIGIT +: DIGIT];

  comparador_digito #(.DIGIT(DIGIT)) u_digito (
    .dig_a (dig_a),
    .dig_b (dig_b),
    .gt    (d_gt),
    .lt    (d_lt)
  );

  assign diff      = d_gt | d_lt;
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last      = (idx_q == '0);
  assign finish    = last || (EARLY_EXIT && diff);
  // The first differing digit decides the result; later digits never override it.
  assign gt_fin    = found_q ? gt_q : d_gt;
  assign found_fin = found_q | diff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (finish) state_d = DONE;
      DONE:    state_d = start ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= LAST_IDX;
      found_q <= 1'b0;
      gt_q    <= 1'b0;
      w_q     <= 1'b0;
      eq_q    <= 1'b1;
    end else if (accept) begin
      a_q     <= word_a ^ MSB_MASK;
      b_q     <= word_b ^ MSB_MASK;
      idx_q   <= LAST_IDX;
      found_q <= 1'b0;
      gt_q    <= 1'b0;
    end else if (state_q == SCAN) begin
      if (!found_q && diff) begin
        found_q <= 1'b1;
        gt_q    <= d_gt;
      end
      if (finish) begin
        w_q  <= gt_fin;
        eq_q <= !found_fin;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign w  = w_q;
  assign z  = !w_q;
  assign eq = eq_q;

endmodule

// File: tb/tb_comparador_secuencial.sv
// Directed table, corner sequences and randomized reference checks for comparador_secuencial.
module tb_comparador_secuencial;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int rnd_done_cnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Directed DUTs: 0 = D1 unsigned early, 1 = D1 unsigned full, 2 = D1 signed early, 3 = D4 unsigned early
  logic       t_rst, t_start;
  logic [7:0] t_a, t_b;
  logic [3:0] t_busy, t_done, t_w, t_z, t_eq;

  comparador_secuencial #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_t0 (
    .clk(clk), .reset(t_rst), .start(t_start), .word_a(t_a), .word_b(t_b),
    .busy(t_busy[0]), .done(t_done[0]), .w(t_w[0]), .z(t_z[0]), .eq(t_eq[0]));
  comparador_secuencial #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_t1 (
    .clk(clk), .reset(t_rst), .start(t_start), .word_a(t_a), .word_b(t_b),
    .busy(t_busy[1]), .done(t_done[1]), .w(t_w[1]), .z(t_z[1]), .eq(t_eq[1]));
  comparador_secuencial #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u_t2 (
    .clk(clk), .reset(t_rst), .start(t_start), .word_a(t_a), .word_b(t_b),
    .busy(t_busy[2]), .done(t_done[2]), .w(t_w[2]), .z(t_z[2]), .eq(t_eq[2]));
  comparador_secuencial #(.WIDTH(8), .DIGIT(4), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_t3 (
    .clk(clk), .reset(t_rst), .start(t_start), .word_a(t_a), .word_b(t_b),
    .busy(t_busy[3]), .done(t_done[3]), .w(t_w[3]), .z(t_z[3]), .eq(t_eq[3]));

  typedef struct {
    int         cfg;
    logic [7:0] a;
    logic [7:0] b;
    logic       w;
    logic       eq;
    int         lat;
  } vec_t;

  vec_t tbl[12];

  task automatic wait_idle();
    int n;
    for (n = 0; n < 50; n++) begin
      if (t_busy == 4'b0000) break;
      @(posedge clk); #1;
    end
    if (n == 50) check("idle_timeout", 0, 1);
  endtask

  // Returns #1 after the accepting edge.
  task automatic launch(input int c, input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    @(negedge clk);
    t_a = a; t_b = b; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    check($sformatf("busy_after_accept_c%0d", c), int'(t_busy[c]), 1);
  endtask

  task automatic wait_done(input int c, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (t_done[c]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, cnt;
    t_rst = 1'b1; t_start = 1'b0; t_a = '0; t_b = '0;
    tbl[0]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 8};
    tbl[1]  = '{0, 8'hE7, 8'h81, 1'b1, 1'b0, 2};
    tbl[2]  = '{0, 8'h81, 8'hE7, 1'b0, 1'b0, 2};
    tbl[3]  = '{0, 8'hFF, 8'hFE, 1'b1, 1'b0, 8};
    tbl[4]  = '{1, 8'hE7, 8'h81, 1'b1, 1'b0, 8};
    tbl[5]  = '{1, 8'h00, 8'h01, 1'b0, 1'b0, 8};
    tbl[6]  = '{2, 8'h80, 8'h01, 1'b0, 1'b0, 1};
    tbl[7]  = '{2, 8'h01, 8'hFF, 1'b1, 1'b0, 1};
    tbl[8]  = '{2, 8'hFF, 8'hFF, 1'b0, 1'b1, 8};
    tbl[9]  = '{3, 8'h6E, 8'h6F, 1'b0, 1'b0, 2};
    tbl[10] = '{3, 8'h7E, 8'h6F, 1'b1, 1'b0, 1};
    tbl[11] = '{3, 8'h5A, 8'h5A, 1'b0, 1'b1, 2};

    #12;
    for (int c = 0; c < 4; c++)
      check($sformatf("reset_outputs_c%0d", c),
            int'({t_busy[c], t_done[c], t_w[c], t_z[c], t_eq[c]}), 5'b00011);
    @(negedge clk);
    t_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(tbl[i].cfg, tbl[i].a, tbl[i].b);
      wait_done(tbl[i].cfg, lat);
      check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("v%0d_w", i), int'(t_w[tbl[i].cfg]), int'(tbl[i].w));
      check($sformatf("v%0d_z", i), int'(t_z[tbl[i].cfg]), int'(!tbl[i].w));
      check($sformatf("v%0d_eq", i), int'(t_eq[tbl[i].cfg]), int'(tbl[i].eq));
    end

    // start and word_a disturbed during SCAN; latched operands must win
    launch(0, 8'h3C, 8'h3C);
    t_start = 1'b1; t_a = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    t_start = 1'b0;
    wait_done(0, lat);
    check("disturb_lat", (lat < 0) ? lat : lat + 3, 8);
    check("disturb_eq", int'(t_eq[0]), 1);
    check("disturb_w", int'(t_w[0]), 0);

    // reset in the middle of a scan, after a result with w=1 eq=0
    launch(0, 8'hC0, 8'h40);
    wait_done(0, lat);
    check("pre_reset_w", int'(t_w[0]), 1);
    launch(0, 8'h55, 8'h55);
    repeat (3) @(posedge clk);
    #1;
    t_rst = 1'b1;
    #1;
    check("midscan_reset_outputs",
          int'({t_busy[0], t_done[0], t_w[0], t_z[0], t_eq[0]}), 5'b00011);
    @(negedge clk);
    t_rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (t_done[0]) cnt++;
    end
    check("no_done_after_reset", cnt, 0);

    // start held in the done cycle begins the next op immediately
    launch(0, 8'h80, 8'h00);
    wait_done(0, lat);
    check("b2b_first_lat", lat, 1);
    check("b2b_first_w", int'(t_w[0]), 1);
    t_a = 8'h00; t_b = 8'h00; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    check("b2b_busy", int'(t_busy[0]), 1);
    check("b2b_done_low", int'(t_done[0]), 0);
    wait_done(0, lat);
    check("b2b_second_lat", lat, 8);
    check("b2b_second_eq", int'(t_eq[0]), 1);
    check("b2b_second_w", int'(t_w[0]), 0);

    for (int n = 0; n < 40000 && rnd_done_cnt < 16; n++) @(posedge clk);
    check("random_finished", rnd_done_cnt, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Randomized configs: DIGIT 1/2/4/8 x SIGNED 0/1 x EARLY_EXIT 1/0
  for (genvar g = 0; g < 16; g++) begin : g_rnd
    localparam int unsigned D = 1 << (g % 4);
    localparam int unsigned N = 8 / D;
    localparam bit          S = ((g / 4) % 2) == 1;
    localparam bit          E = (g < 8);

    logic       rrst, st;
    logic [7:0] ra, rb;
    logic       bsy, dn, rw, rz, req;

    comparador_secuencial #(.WIDTH(8), .DIGIT(D), .SIGNED(S), .EARLY_EXIT(E)) u_dut (
      .clk(clk), .reset(rrst), .start(st), .word_a(ra), .word_b(rb),
      .busy(bsy), .done(dn), .w(rw), .z(rz), .eq(req));

    initial begin
      logic [7:0] sa, sb, dx;
      logic       ew;
      int         lat, el, p;
      rrst = 1'b1; st = 1'b0; ra = '0; rb = '0;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rnd%0d_reset", g), int'({bsy, dn, rw, rz, req}), 5'b00011);
      rrst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        sa = 8'($urandom);
        sb = ($urandom_range(0, 7) == 0) ? sa : 8'($urandom);
        ra = sa; rb = sb; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        ra = 8'($urandom);
        rb = 8'($urandom);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
          @(posedge clk); #1;
          if (dn) begin
            lat = c;
            break;
          end
        end
        ew = S ? ($signed(sa) > $signed(sb)) : (sa > sb);
        dx = sa ^ sb;
        if (!E || dx == 0) el = N;
        else begin
          p = 7;
          while (!dx[p]) p--;
          el = (7 - p) / D + 1;
        end
        check($sformatf("rnd%0d_lat a=%0h b=%0h", g, sa, sb), lat, el);
        check($sformatf("rnd%0d_w a=%0h b=%0h", g, sa, sb), int'(rw), int'(ew));
        check($sformatf("rnd%0d_z a=%0h b=%0h", g, sa, sb), int'(rz), int'(!ew));
        check($sformatf("rnd%0d_eq a=%0h b=%0h", g, sa, sb), int'(req), int'(sa == sb));
      end
      rnd_done_cnt++;
    end
  end

endmodule
